// File: rtl/pkt_uart_pkg.sv
// Shared definitions for the packet UART transmitter and receiver:
// payload geometry, checksum width, serializer state encodings and helpers.
package pkt_uart_pkg;

  localparam int PAYLOAD_W  = 128;
  localparam int BYTE_NUM   = 16;
  localparam int CHK_W      = 8;
  localparam int BYTE_IDX_W = 5;   // wide enough to also index the checksum byte

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Select byte idx of a payload; out-of-range indices yield zero.
  function automatic logic [7:0] pick_byte(input logic [PAYLOAD_W-1:0] p,
                                           input logic [BYTE_IDX_W-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < BYTE_NUM; k++) begin
      if (idx == BYTE_IDX_W'(k)) begin
        b = p[8*k +: 8];
      end
    end
    return b;
  endfunction

  // Modulo-256 sum of all payload bytes.
  function automatic logic [CHK_W-1:0] byte_sum(input logic [PAYLOAD_W-1:0] p);
    logic [CHK_W-1:0] s;
    s = 8'h00;
    for (int k = 0; k < BYTE_NUM; k++) begin
      s = s + p[8*k +: 8];
    end
    return s;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serializer. A byte is loaded when start is high while
// ready is high; ready is also high in the last cycle of the stop bit so a
// following byte starts with no idle gap.
module uart_byte_tx
  import pkt_uart_pkg::*;
#(
  parameter int BPS_CNT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic       txd,
  output logic       ready
);

  localparam int BW = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

  uart_state_t   state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    data;
  logic          baud_end;

  assign baud_end = (baud_cnt == BW'(BPS_CNT - 1));

  // Ready to take a byte when idle or finishing the current stop bit.
  always_comb begin
    if (state == ST_IDLE) begin
      ready = 1'b1;
    end else if (state == ST_STOP) begin
      ready = baud_end;
    end else begin
      ready = 1'b0;
    end
  end

  // Serializer FSM; txd is driven from a register so the line never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      data     <= 8'h00;
      txd      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_START;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            data     <= din;
            txd      <= 1'b0;
          end else begin
            txd <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_end) begin
            state    <= ST_DATA;
            baud_cnt <= '0;
            txd      <= data[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= ST_STOP;
              txd   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              txd     <= data[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (start) begin
              state   <= ST_START;
              bit_cnt <= 3'd0;
              data    <= din;
              txd     <= 1'b0;
            end else begin
              state <= ST_IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          bit_cnt  <= 3'd0;
          txd      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/pkt_uart_tx.sv
// 16-byte packet UART transmitter: captures a 128-bit payload on request and
// sends bytes 0..15 back-to-back in 8N1 framing through uart_byte_tx.
// Optional macro PKT_UART_TX_CHKSUM_EN appends a 17th byte holding the
// modulo-256 sum of the payload bytes.
module pkt_uart_tx
  import pkt_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 uart_en,
  input  logic [PAYLOAD_W-1:0] uart_din,
  output logic                 uart_tx_busy,
  output logic                 uart_tx_done,
  output logic                 uart_txd
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;

`ifdef PKT_UART_TX_CHKSUM_EN
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTE_NUM);
  logic [CHK_W-1:0] chksum;
`else
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTE_NUM - 1);
`endif

  logic [PAYLOAD_W-1:0]  shadow;
  logic [BYTE_IDX_W-1:0] byte_cnt;
  logic [BYTE_IDX_W-1:0] nxt_idx;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  byte_start;
  logic                  accept;
  logic                  advance;
  logic                  finish;
  logic                  last_byte;

  assign accept     = uart_en & ~uart_tx_busy;
  assign last_byte  = (byte_cnt == LAST_IDX);
  assign advance    = uart_tx_busy & byte_ready & ~last_byte;
  assign finish     = uart_tx_busy & byte_ready & last_byte;
  assign byte_start = accept | advance;
  assign nxt_idx    = byte_cnt + BYTE_IDX_W'(1);

  // First byte comes straight from the input so it can start on the accept edge.
  always_comb begin
    if (accept) begin
      byte_data = uart_din[7:0];
`ifdef PKT_UART_TX_CHKSUM_EN
    end else if (nxt_idx == LAST_IDX) begin
      byte_data = chksum;
`endif
    end else begin
      byte_data = pick_byte(shadow, nxt_idx);
    end
  end

  // Packet sequencing: capture payload, step through bytes, flag completion.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      shadow       <= '0;
      byte_cnt     <= '0;
      uart_tx_busy <= 1'b0;
      uart_tx_done <= 1'b0;
`ifdef PKT_UART_TX_CHKSUM_EN
      chksum       <= '0;
`endif
    end else begin
      uart_tx_done <= 1'b0;
      if (accept) begin
        shadow       <= uart_din;
        byte_cnt     <= '0;
        uart_tx_busy <= 1'b1;
`ifdef PKT_UART_TX_CHKSUM_EN
        chksum       <= byte_sum(uart_din);
`endif
      end else if (advance) begin
        byte_cnt <= nxt_idx;
      end else if (finish) begin
        uart_tx_busy <= 1'b0;
        uart_tx_done <= 1'b1;
      end
    end
  end

  uart_byte_tx #(
    .BPS_CNT(BPS_CNT)
  ) u_byte_tx (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .start(byte_start),
    .din  (byte_data),
    .txd  (uart_txd),
    .ready(byte_ready)
  );

endmodule

// File: tb/tb_pkt_uart_tx.sv
// Directed bench for pkt_uart_tx, run with a short bit time (10 cycles) so
// full packets fit in a short simulation. The line is compared every cycle
// against the expected 8N1 waveform built from the payload.
module tb_pkt_uart_tx;

  localparam int CLK_FREQ = 1000;
  localparam int UART_BPS = 100;
  localparam int B        = CLK_FREQ / UART_BPS;
`ifdef PKT_UART_TX_CHKSUM_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic         uart_en = 1'b0;
  logic [127:0] uart_din = '0;
  logic         uart_tx_busy;
  logic         uart_tx_done;
  logic         uart_txd;

  int checks = 0;
  int errors = 0;

  pkt_uart_tx #(
    .CLK_FREQ(CLK_FREQ),
    .UART_BPS(UART_BPS)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .uart_en     (uart_en),
    .uart_din    (uart_din),
    .uart_tx_busy(uart_tx_busy),
    .uart_tx_done(uart_tx_done),
    .uart_txd    (uart_txd)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [127:0] p, input int k);
    logic [7:0] s;
    if (k < 16) begin
      return p[8*k +: 8];
    end
    s = 8'h00;
    for (int j = 0; j < 16; j++) s = s + p[8*j +: 8];
    return s;
  endfunction

  // Called #1 after the accepting edge. Checks every cycle of the packet and
  // the done cycle. Optionally changes din and pulses uart_en at cycle poke_t.
  task automatic check_packet(input string tag, input logic [127:0] exp,
                              input int poke_t, input logic [127:0] poke_din);
    int total, line_err, busy_err, done_err, busy_cyc, k, pos;
    logic [7:0] bt;
    logic expbit;
    total = NB * 10 * B;
    line_err = 0; busy_err = 0; done_err = 0; busy_cyc = 0;
    for (int t = 0; t < total; t++) begin
      k   = t / (10 * B);
      pos = (t / B) % 10;
      bt  = exp_byte(exp, k);
      if (pos == 0) expbit = 1'b0;
      else if (pos == 9) expbit = 1'b1;
      else expbit = bt[pos-1];
      if (uart_txd !== expbit) line_err++;
      if (uart_tx_busy === 1'b1) busy_cyc++;
      else busy_err++;
      if (uart_tx_done !== 1'b0) done_err++;
      if (poke_t >= 0 && t == poke_t) begin
        uart_din = poke_din;
        uart_en  = 1'b1;
      end else if (poke_t >= 0 && t == poke_t + 1) begin
        uart_en = 1'b0;
      end
      step();
    end
    chk({tag, "_line_errs"}, 32'(line_err), 32'd0);
    chk({tag, "_busy_low_in_pkt"}, 32'(busy_err), 32'd0);
    chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(NB * 10 * B));
    chk({tag, "_early_done"}, 32'(done_err), 32'd0);
    chk({tag, "_end_busy"}, 32'(uart_tx_busy), 32'd0);
    chk({tag, "_end_done"}, 32'(uart_tx_done), 32'd1);
    chk({tag, "_end_txd"}, 32'(uart_txd), 32'd1);
  endtask

  localparam logic [127:0] P_SEQ = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] P_A5  = {16{8'hA5}};
  localparam logic [127:0] P_MIX = 128'h00FF_8001_7E3C_C3AA_5512_3456_789A_BCDE;

  initial begin
    int idle_err;
    // Reset state
    step();
    step();
    chk("rst_txd", 32'(uart_txd), 32'd1);
    chk("rst_busy", 32'(uart_tx_busy), 32'd0);
    chk("rst_done", 32'(uart_tx_done), 32'd0);

    // Accept on the first edge after reset release; din changes right after
    sys_rst  = 1'b0;
    uart_din = P_SEQ;
    uart_en  = 1'b1;
    step();
    uart_en  = 1'b0;
    uart_din = P_MIX;
    chk("pkt1_start_txd", 32'(uart_txd), 32'd0);
    check_packet("pkt1", P_SEQ, -1, '0);
    step();
    chk("pkt1_done_pulse_end", 32'(uart_tx_done), 32'd0);
    chk("pkt1_idle_busy", 32'(uart_tx_busy), 32'd0);

    // Request and din change at cycle 100 of a packet are ignored
    uart_din = P_MIX;
    uart_en  = 1'b1;
    step();
    uart_en  = 1'b0;
    check_packet("poke", P_MIX, 100, P_A5);
    step();
    chk("poke_no_requeue_busy", 32'(uart_tx_busy), 32'd0);
    chk("poke_no_requeue_txd", 32'(uart_txd), 32'd1);

    // uart_en held high: packets separated by exactly one idle cycle
    uart_din = P_A5;
    uart_en  = 1'b1;
    step();
    check_packet("b2b1", P_A5, -1, '0);
    step();
    check_packet("b2b2", P_A5, -1, '0);
    uart_en = 1'b0;
    step();
    chk("b2b_stop_busy", 32'(uart_tx_busy), 32'd0);
    chk("b2b_stop_done", 32'(uart_tx_done), 32'd0);

    // Reset mid-packet aborts immediately and does not resume
    uart_din = P_SEQ;
    uart_en  = 1'b1;
    step();
    uart_en  = 1'b0;
    repeat (203) step();
    chk("abort_line_low", 32'(uart_txd), 32'd0);   // start bit of byte 2
    sys_rst = 1'b1;
    #1;
    chk("abort_txd", 32'(uart_txd), 32'd1);
    chk("abort_busy", 32'(uart_tx_busy), 32'd0);
    chk("abort_done", 32'(uart_tx_done), 32'd0);
    step();
    step();
    sys_rst  = 1'b0;
    idle_err = 0;
    for (int i = 0; i < 40; i++) begin
      if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0 || uart_tx_done !== 1'b0) idle_err++;
      step();
    end
    chk("abort_no_resume", 32'(idle_err), 32'd0);

    // Fresh packet after the abort
    uart_din = P_MIX;
    uart_en  = 1'b1;
    step();
    uart_en  = 1'b0;
    check_packet("post_rst", P_MIX, -1, '0);
    step();
    chk("post_rst_idle", 32'(uart_tx_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
